// File: rtl/ps2_key_ctrl_if.sv
// rtl/ps2_key_ctrl_if.sv - PS/2 receiver FIFO handshake bundle
interface ps2_key_ctrl_if;
  logic       ready;
  logic [7:0] data;
  logic       overflow;
  logic       nextdata_n;

  // FIFO side: presents bytes and flags, receives the pop strobe
  modport master (
    output ready,
    output data,
    output overflow,
    input  nextdata_n
  );

  // Sequencer side: consumes bytes and issues the pop strobe
  modport slave (
    input  ready,
    input  data,
    input  overflow,
    output nextdata_n
  );
endinterface

// File: rtl/ps2_key_ctrl.sv
// rtl/ps2_key_ctrl.sv - PS/2 scan-byte sequencer with modifier tracking and press counting
module ps2_key_ctrl #(
  parameter int         CNT_W   = 8,
  parameter logic [7:0] SHIFT_L = 8'h12,
  parameter logic [7:0] SHIFT_R = 8'h59,
  parameter logic [7:0] CTRL_C  = 8'h14,
  parameter logic [7:0] CAPS_C  = 8'h58
) (
  input  logic             clk_50,
  input  logic             reset,
  ps2_key_ctrl_if.slave    fifo,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_down,
  output logic             shift_on,
  output logic             ctrl_on,
  output logic             caps_on,
  output logic [CNT_W-1:0] press_cnt,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, DECODE, GAP} state_t;

  state_t     state;
  logic [7:0] byte_r;
  logic       ext_f;
  logic       brk_f;
  logic [7:0] held_code;
  logic       held_ext;
  logic       caps_held;

  // Pop one byte, decode it the following cycle, then idle one cycle so ready can settle
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state           <= IDLE;
      byte_r          <= 8'h00;
      ext_f           <= 1'b0;
      brk_f           <= 1'b0;
      held_code       <= 8'h00;
      held_ext        <= 1'b0;
      caps_held       <= 1'b0;
      fifo.nextdata_n <= 1'b1;
      key_valid       <= 1'b0;
      key_code        <= 8'h00;
      key_ext         <= 1'b0;
      key_down        <= 1'b0;
      shift_on        <= 1'b0;
      ctrl_on         <= 1'b0;
      caps_on         <= 1'b0;
      press_cnt       <= '0;
      err             <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (fifo.overflow) begin
        err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (fifo.ready) begin
            byte_r          <= fifo.data;
            fifo.nextdata_n <= 1'b0;
            state           <= DECODE;
          end
        end
        DECODE: begin
          fifo.nextdata_n <= 1'b1;
          state           <= GAP;
          if (byte_r == 8'hE0) begin
            ext_f <= 1'b1;
          end else if (byte_r == 8'hF0) begin
            brk_f <= 1'b1;
          end else if (brk_f) begin
            // Release: drop modifiers, and clear key_down only for the key currently held
            if (byte_r == SHIFT_L || byte_r == SHIFT_R) shift_on <= 1'b0;
            if (byte_r == CTRL_C) ctrl_on <= 1'b0;
            if (byte_r == CAPS_C) caps_held <= 1'b0;
            if (byte_r == held_code && ext_f == held_ext) key_down <= 1'b0;
            ext_f <= 1'b0;
            brk_f <= 1'b0;
          end else begin
            // Make: modifiers update state only; other keys pulse unless typematic repeat
            if (byte_r == SHIFT_L || byte_r == SHIFT_R) begin
              shift_on <= 1'b1;
            end else if (byte_r == CTRL_C) begin
              ctrl_on <= 1'b1;
            end else if (byte_r == CAPS_C) begin
              if (!caps_held) begin
                caps_on   <= ~caps_on;
                caps_held <= 1'b1;
              end
            end else if (!(key_down && byte_r == held_code && ext_f == held_ext)) begin
              key_valid <= 1'b1;
              key_code  <= byte_r;
              key_ext   <= ext_f;
              held_code <= byte_r;
              held_ext  <= ext_f;
              key_down  <= 1'b1;
              press_cnt <= press_cnt + CNT_W'(1);
            end
            ext_f <= 1'b0;
            brk_f <= 1'b0;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// tb/tb_ps2_key_ctrl.sv - directed self-checking bench for ps2_key_ctrl
module tb_ps2_key_ctrl;
  logic       clk_50;
  logic       reset;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_down;
  logic       shift_on;
  logic       ctrl_on;
  logic       caps_on;
  logic [7:0] press_cnt;
  logic       err;

  int n_checks;
  int n_fail;
  int pop_cnt;
  int pulse_cnt;
  logic last_valid;

  ps2_key_ctrl_if bus ();

  ps2_key_ctrl dut (
    .clk_50    (clk_50),
    .reset     (reset),
    .fifo      (bus.slave),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ext   (key_ext),
    .key_down  (key_down),
    .shift_on  (shift_on),
    .ctrl_on   (ctrl_on),
    .caps_on   (caps_on),
    .press_cnt (press_cnt),
    .err       (err)
  );

  initial clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  // Monitors: count pop strobes and key_valid pulses
  always @(negedge clk_50) begin
    if (bus.nextdata_n === 1'b0) pop_cnt++;
    if (key_valid === 1'b1) pulse_cnt++;
  end

  task automatic do_reset();
    reset = 1'b1;
    bus.ready = 1'b0;
    bus.data = 8'h00;
    bus.overflow = 1'b0;
    @(negedge clk_50);
    @(negedge clk_50);
    reset = 1'b0;
    @(negedge clk_50);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    bus.ready = 1'b1;
    bus.data = b;
    while (t < 20) begin
      @(negedge clk_50);
      if (bus.nextdata_n === 1'b0) break;
      t++;
    end
    n_checks++;
    if (t >= 20) begin
      n_fail++;
      $display("FAIL pop_timeout byte %h: nextdata_n never went low within 20 cycles", b);
    end
    bus.ready = 1'b0;
    @(negedge clk_50);
    last_valid = key_valid;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.nextdata_n !== 1'b1) begin n_fail++; $display("FAIL reset_nextdata_n got %b exp 1", bus.nextdata_n); end
    n_checks++;
    if ({key_valid, key_code, key_ext, key_down, shift_on, ctrl_on, caps_on, press_cnt, err} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h exp 0", {key_valid, key_code, key_ext, key_down, shift_on, ctrl_on, caps_on, press_cnt, err});
    end
  endtask

  task automatic test_single();
    int p0;
    p0 = pulse_cnt;
    send_byte(8'h1C);
    n_checks++;
    if (last_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", last_valid); end
    n_checks++;
    if (key_code !== 8'h1C || key_ext !== 1'b0) begin n_fail++; $display("FAIL single_code got %h/%b exp 1c/0", key_code, key_ext); end
    n_checks++;
    if (press_cnt !== 8'd1) begin n_fail++; $display("FAIL single_cnt got %0d exp 1", press_cnt); end
    n_checks++;
    if (key_down !== 1'b1) begin n_fail++; $display("FAIL single_down got %b exp 1", key_down); end
    send_byte(8'hF0);
    send_byte(8'h1C);
    n_checks++;
    if (key_down !== 1'b0) begin n_fail++; $display("FAIL single_release got %b exp 0", key_down); end
    n_checks++;
    if (pulse_cnt - p0 !== 1) begin n_fail++; $display("FAIL single_pulses got %0d exp 1", pulse_cnt - p0); end
  endtask

  task automatic test_typematic();
    int p0;
    int q0;
    logic [7:0] c0;
    p0 = pulse_cnt;
    q0 = pop_cnt;
    c0 = press_cnt;
    for (int i = 0; i < 5; i++) send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h1C);
    n_checks++;
    if (pulse_cnt - p0 !== 1) begin n_fail++; $display("FAIL typematic_pulses got %0d exp 1", pulse_cnt - p0); end
    n_checks++;
    if (press_cnt !== c0 + 8'd1) begin n_fail++; $display("FAIL typematic_cnt got %0d exp %0d", press_cnt, c0 + 8'd1); end
    n_checks++;
    if (pop_cnt - q0 !== 7) begin n_fail++; $display("FAIL typematic_pops got %0d exp 7", pop_cnt - q0); end
  endtask

  task automatic test_shift();
    send_byte(8'h12);
    n_checks++;
    if (last_valid !== 1'b0 || shift_on !== 1'b1) begin n_fail++; $display("FAIL shift_make got valid %b shift %b exp 0 1", last_valid, shift_on); end
    send_byte(8'h1C);
    n_checks++;
    if (last_valid !== 1'b1 || shift_on !== 1'b1) begin n_fail++; $display("FAIL shift_key got valid %b shift %b exp 1 1", last_valid, shift_on); end
    send_byte(8'hF0);
    send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h12);
    n_checks++;
    if (shift_on !== 1'b0 || key_code !== 8'h1C) begin n_fail++; $display("FAIL shift_release got shift %b code %h exp 0 1c", shift_on, key_code); end
  endtask

  task automatic test_ext();
    send_byte(8'hE0);
    send_byte(8'h75);
    n_checks++;
    if (last_valid !== 1'b1 || key_code !== 8'h75 || key_ext !== 1'b1) begin
      n_fail++; $display("FAIL ext_make got valid %b code %h ext %b exp 1 75 1", last_valid, key_code, key_ext);
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    n_checks++;
    if (key_down !== 1'b0) begin n_fail++; $display("FAIL ext_release got %b exp 0", key_down); end
    send_byte(8'h75);
    n_checks++;
    if (last_valid !== 1'b1 || key_ext !== 1'b0) begin n_fail++; $display("FAIL ext_cleared got valid %b ext %b exp 1 0", last_valid, key_ext); end
    send_byte(8'hF0);
    send_byte(8'h75);
  endtask

  task automatic test_caps();
    int p0;
    logic [7:0] c0;
    p0 = pulse_cnt;
    c0 = press_cnt;
    send_byte(8'h58);
    n_checks++;
    if (caps_on !== 1'b1) begin n_fail++; $display("FAIL caps_first got %b exp 1", caps_on); end
    send_byte(8'h58);
    send_byte(8'h58);
    n_checks++;
    if (caps_on !== 1'b1) begin n_fail++; $display("FAIL caps_repeat got %b exp 1", caps_on); end
    send_byte(8'hF0);
    send_byte(8'h58);
    send_byte(8'h58);
    n_checks++;
    if (caps_on !== 1'b0) begin n_fail++; $display("FAIL caps_second got %b exp 0", caps_on); end
    n_checks++;
    if (pulse_cnt !== p0 || press_cnt !== c0) begin n_fail++; $display("FAIL caps_nopulse got pulses %0d cnt %0d exp 0 %0d", pulse_cnt - p0, press_cnt, c0); end
    send_byte(8'hF0);
    send_byte(8'h58);
  endtask

  task automatic test_ctrl();
    send_byte(8'hE0);
    send_byte(8'h14);
    n_checks++;
    if (ctrl_on !== 1'b1 || last_valid !== 1'b0) begin n_fail++; $display("FAIL ctrl_make got ctrl %b valid %b exp 1 0", ctrl_on, last_valid); end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h14);
    n_checks++;
    if (ctrl_on !== 1'b0) begin n_fail++; $display("FAIL ctrl_release got %b exp 0", ctrl_on); end
  endtask

  task automatic test_rollover();
    send_byte(8'h1C);
    send_byte(8'h32);
    n_checks++;
    if (last_valid !== 1'b1 || key_code !== 8'h32) begin n_fail++; $display("FAIL roll_new got valid %b code %h exp 1 32", last_valid, key_code); end
    send_byte(8'hF0);
    send_byte(8'h1C);
    n_checks++;
    if (key_down !== 1'b1) begin n_fail++; $display("FAIL roll_old_break got %b exp 1", key_down); end
    send_byte(8'hF0);
    send_byte(8'h32);
    n_checks++;
    if (key_down !== 1'b0) begin n_fail++; $display("FAIL roll_release got %b exp 0", key_down); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 255; i++) send_byte((i % 2 == 0) ? 8'h1C : 8'h32);
    n_checks++;
    if (press_cnt !== 8'd255) begin n_fail++; $display("FAIL wrap_max got %0d exp 255", press_cnt); end
    send_byte(8'h32);
    n_checks++;
    if (press_cnt !== 8'd0) begin n_fail++; $display("FAIL wrap_zero got %0d exp 0", press_cnt); end
  endtask

  task automatic test_overflow();
    bus.overflow = 1'b1;
    @(negedge clk_50);
    bus.overflow = 1'b0;
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b exp 1", err); end
    send_byte(8'h1C);
    n_checks++;
    if (err !== 1'b1 || last_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got err %b valid %b exp 1 1", err, last_valid); end
  endtask

  task automatic test_reset_decode();
    int t;
    int q0;
    t = 0;
    bus.ready = 1'b1;
    bus.data = 8'h4D;
    while (t < 20) begin
      @(negedge clk_50);
      if (bus.nextdata_n === 1'b0) break;
      t++;
    end
    n_checks++;
    if (t >= 20) begin n_fail++; $display("FAIL rstdec_timeout: nextdata_n never went low"); end
    reset = 1'b1;
    bus.ready = 1'b0;
    @(negedge clk_50);
    n_checks++;
    if (bus.nextdata_n !== 1'b1) begin n_fail++; $display("FAIL rstdec_nextdata_n got %b exp 1", bus.nextdata_n); end
    n_checks++;
    if ({key_valid, key_code, key_ext, key_down, shift_on, ctrl_on, caps_on, press_cnt, err} !== 23'd0) begin
      n_fail++;
      $display("FAIL rstdec_outputs got %h exp 0", {key_valid, key_code, key_ext, key_down, shift_on, ctrl_on, caps_on, press_cnt, err});
    end
    reset = 1'b0;
    q0 = pop_cnt;
    for (int i = 0; i < 4; i++) @(negedge clk_50);
    n_checks++;
    if (pop_cnt !== q0 || key_code !== 8'h00) begin n_fail++; $display("FAIL rstdec_discard got pops %0d code %h exp 0 00", pop_cnt - q0, key_code); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    pop_cnt = 0;
    pulse_cnt = 0;
    last_valid = 1'b0;
    reset = 1'b1;
    bus.ready = 1'b0;
    bus.data = 8'h00;
    bus.overflow = 1'b0;
    @(negedge clk_50);
    test_reset();
    test_single();
    test_typematic();
    test_shift();
    test_ext();
    test_caps();
    test_ctrl();
    test_rollover();
    test_wrap();
    test_overflow();
    test_reset_decode();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
